// File: rtl/matmul_pkg.sv
// Shared definitions for the 3x3 serial matrix multiplier datapath:
// element width, dimension, loader state encoding and flat-bus addressing.
package matmul_pkg;

  localparam int DATA_W = 16;
  localparam int N      = 3;

  typedef enum logic [1:0] {
    LOAD_A    = 2'd0,
    LOAD_B    = 2'd1,
    FIRE      = 2'd2,
    WAIT_DONE = 2'd3
  } loader_state_e;

  // Bit offset of element (r,c) in a row-major flattened n x n matrix of w-bit words.
  function automatic int unsigned elem_off(input int unsigned r,
                                           input int unsigned c,
                                           input int unsigned n = N,
                                           input int unsigned w = DATA_W);
    return (r * n + c) * w;
  endfunction

endpackage

// File: rtl/matrix_operand_loader.sv
// Streams 2*N*N words into operand matrices A then B, fires the multiplier and
// holds the operands until done. Optional framing check: MATLOAD_FRAME_CHK_EN.
module matrix_operand_loader #(
  parameter int DATA_W = matmul_pkg::DATA_W,
  parameter int N      = matmul_pkg::N
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  output logic [N*N*DATA_W-1:0] a_flat,
  output logic [N*N*DATA_W-1:0] b_flat,
  output logic                  mul_start,
  input  logic                  mul_done,
  output logic                  busy,
  output logic                  frame_err
);
  import matmul_pkg::*;

  localparam int               IDX_W    = (N * N > 1) ? $clog2(N * N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N * N - 1);

  loader_state_e         state_r;
  logic [IDX_W-1:0]      idx_r;
  logic                  mul_done_q;
  logic [N*N*DATA_W-1:0] a_flat_r;
  logic [N*N*DATA_W-1:0] b_flat_r;
  logic                  mul_start_r;
  logic                  busy_r;
  logic                  xfer_s;
  logic                  frame_bad_s;

  assign in_ready  = (state_r == LOAD_A) || (state_r == LOAD_B);
  assign xfer_s    = in_valid && in_ready;
  assign a_flat    = a_flat_r;
  assign b_flat    = b_flat_r;
  assign mul_start = mul_start_r;
  assign busy      = busy_r;

`ifdef MATLOAD_FRAME_CHK_EN
  logic frame_err_r;

  // in_last must flag exactly the final B word of a job, and no other word.
  assign frame_bad_s = xfer_s &&
                       (in_last != ((state_r == LOAD_B) && (idx_r == LAST_IDX)));
  assign frame_err   = frame_err_r;

  // One-cycle error pulse following the offending transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err_r <= 1'b0;
    end else begin
      frame_err_r <= frame_bad_s;
    end
  end
`else
  logic unused_in_last_s;

  assign unused_in_last_s = in_last;
  assign frame_bad_s      = 1'b0;
  assign frame_err        = 1'b0;
`endif

  // Job sequencing, operand capture and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= LOAD_A;
      idx_r       <= '0;
      mul_done_q  <= 1'b0;
      a_flat_r    <= '0;
      b_flat_r    <= '0;
      mul_start_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      mul_done_q  <= mul_done;
      mul_start_r <= 1'b0;
      case (state_r)
        LOAD_A: begin
          if (xfer_s) begin
            a_flat_r[idx_r*DATA_W +: DATA_W] <= in_data;
            if (frame_bad_s) begin
              idx_r <= '0;
            end else if (idx_r == LAST_IDX) begin
              idx_r   <= '0;
              state_r <= LOAD_B;
            end else begin
              idx_r <= idx_r + IDX_W'(1);
            end
          end
        end
        LOAD_B: begin
          if (xfer_s) begin
            b_flat_r[idx_r*DATA_W +: DATA_W] <= in_data;
            if (frame_bad_s) begin
              idx_r   <= '0;
              state_r <= LOAD_A;
            end else if (idx_r == LAST_IDX) begin
              idx_r       <= '0;
              state_r     <= FIRE;
              mul_start_r <= 1'b1;
              busy_r      <= 1'b1;
            end else begin
              idx_r <= idx_r + IDX_W'(1);
            end
          end
        end
        FIRE: begin
          state_r <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // Only a fresh rising edge ends the wait; a level already high is ignored.
          if (mul_done && !mul_done_q) begin
            state_r <= LOAD_A;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= LOAD_A;
          idx_r   <= '0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/matrix_operand_loader.md
# matrix_operand_loader

Upstream feeder for the 3x3 serial matrix multiplier. Accepts a stream of 16-bit words over a valid/ready handshake and assembles operand matrices A and B, row-major, A first. It then issues a one-cycle start to the multiplier and holds both operands stable until the multiplier reports done. It stops accepting input while a multiply is in flight, which gives the design back-pressure.

## Interface
- DATA_W, 16, element width in bits
- N, 3, matrix dimension; one job is 2*N*N words
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- in_data  in  DATA_W  operand word
- in_valid  in  1  in_data is valid
- in_ready  out  1  loader accepts a word this cycle
- in_last  in  1  marks the final word of a job; used only with MATLOAD_FRAME_CHK_EN
- a_flat  out  N*N*DATA_W  matrix A; element (r,c) at bits [(r*N+c)*DATA_W +: DATA_W]
- b_flat  out  N*N*DATA_W  matrix B; same layout
- mul_start  out  1  one-cycle start pulse to the multiplier
- mul_done  in  1  multiplier done level
- busy  out  1  a multiply is in flight
- frame_err  out  1  one-cycle framing-error pulse

## Operation
- States: LOAD_A, LOAD_B, FIRE, WAIT_DONE. The reset state is LOAD_A.
- Word counter idx runs 0..N*N-1 and is reset to 0.
- A transfer occurs on a clock edge where in_valid && in_ready.
- in_ready = 1 in LOAD_A and LOAD_B, 0 otherwise. It is combinational from state.
- LOAD_A: each transfer writes A[idx/N][idx%N] and increments idx. The transfer at idx = N*N-1 clears idx and moves to LOAD_B.
- LOAD_B: same behaviour into B. The last transfer moves to FIRE.
- FIRE: mul_start = 1 for exactly this one cycle, then unconditionally moves to WAIT_DONE.
- WAIT_DONE: exits to LOAD_A on the rising edge of mul_done, detected against a registered copy mul_done_q.
  - A level that was already high on entry is ignored.
  - mul_done_q resets to 0.
- busy = 1 in FIRE and WAIT_DONE.
- Operand registers are written only on transfers. a_flat and b_flat therefore stay constant from FIRE until the first transfer of the next job.
- Width rule: words are stored as received. There is no arithmetic, truncation or sign handling.
- A deasserted in_valid stalls loading indefinitely with no timeout. Gaps between words are legal.
- in_data is ignored when no transfer occurs.
- Reset values: a_flat = 0, b_flat = 0, mul_start = 0, busy = 0, frame_err = 0, in_ready = 1 once in LOAD_A.
- Reset mid-operation, any state: all state is cleared to the reset values, the partial job is discarded and idx = 0. A multiply already in flight is not aborted by this block.

## Timing
- mul_start rises in the cycle after the edge that accepts the final B word.
- Minimum job cadence is 2*N*N + 1 + T_mul + 1 cycles, where T_mul is the multiplier latency.
- in_ready falls in the same cycle mul_start rises.
- in_ready rises in the cycle after the edge where the mul_done rising edge is seen.
- frame_err is registered: it is high for one cycle, starting the cycle after the offending transfer.

## Configuration
- MATLOAD_FRAME_CHK_EN defined:
  - in_last high on any word other than word 2*N*N-1 of a job is a framing error.
  - in_last low on word 2*N*N-1 is also a framing error.
  - On a framing error: frame_err pulses, the job is discarded, the state returns to LOAD_A with idx = 0, and mul_start is not issued.
  - Operand registers keep their partially written values. They are overwritten by the next job.
- MATLOAD_FRAME_CHK_EN undefined: in_last is ignored, frame_err is tied to 0, and no checker logic is present.

## Structure
- Shared package matmul_pkg contains:
  - DATA_W and N defaults
  - the loader state enum typedef
  - a function that returns the flat bit offset of element (r,c)
- No sub-module. The FSM, counter and optional checker are one block.

## Test plan
- Job of words 1..9 for A and 10..18 for B, in_last on word 18, mul_done rising 10 cycles after start:
  - A(0,0)=1, A(2,2)=9, B(0,0)=10, B(2,2)=18.
  - Exactly one mul_start pulse, one cycle after the 18th transfer.
  - in_ready = 0 until the cycle after mul_done rises.
- Same job with in_valid toggling randomly at 50% duty: identical operands and a single mul_start.
- mul_done held high on entry to WAIT_DONE: the loader stays in WAIT_DONE until mul_done falls and rises again.
- reset asserted after 12 words:
  - a_flat = 0, b_flat = 0, busy = 0.
  - The next 18 words form a complete, correct job.
- With MATLOAD_FRAME_CHK_EN, in_last on word 5:
  - frame_err pulses once, no mul_start.
  - The next well-formed 18-word job starts at A(0,0).
- With MATLOAD_FRAME_CHK_EN, in_last missing on word 18: frame_err pulses and mul_start is never asserted.
